ctr_batch_scheduler: RTL
========================

CTR_BATCH_SCHEDULER -- requirements
Module: ctr_batch_scheduler

Interface
REQ-001 Parameter BATCH_BLOCKS, default 4, number of parallel AES-256 cores per batch.
REQ-002 Parameter CTR_W, default 6, counter width; the maximum job length is 2^CTR_W blocks.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 job_valid / job_ready  in / out  1 / 1  job request handshake.
REQ-006 job_nonce  in  16  nonce_a in bits [15:8], nonce_b in bits [7:0].
REQ-007 job_nblocks  in  CTR_W  block count; value 0 means 2^CTR_W (64).
REQ-008 abort  in  1  single-cycle pulse that cancels the current job.
REQ-009 eng_start  out  1  single-cycle pulse that launches one batch on the AES engine.
REQ-010 eng_nonce / eng_ctr  out  16 / CTR_W  base IV fields; held stable from eng_start until eng_done.
REQ-011 eng_done  in  1  single-cycle pulse; eng_batch is valid in the same cycle.
REQ-012 eng_batch  in  BATCH_BLOCKS*128  keystream; block i sits at bits [128i+127:128i].
REQ-013 ks_valid / ks_ready  out / in  1 / 1  keystream output handshake.
REQ-014 ks_data  out  BATCH_BLOCKS*128  registered keystream batch.
REQ-015 ks_mask  out  BATCH_BLOCKS  per-block valid flags.
REQ-016 ks_last  out  1  final batch of the job.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 States are IDLE, ISSUE, WAIT, HOLD and DRAIN.
REQ-019 IDLE: job_ready=1; on job_valid, latch nonce and remaining count (0 maps to 64), clear ctr to 0, and go to ISSUE.
REQ-020 ISSUE: assert eng_start for exactly one cycle, then go to WAIT.
REQ-021 WAIT: on eng_done, capture eng_batch, mask and last into the output register, set ks_valid=1, and go to HOLD.
REQ-022 Mask rule: remaining >= BATCH_BLOCKS gives all ones; otherwise (1<<remaining)-1; block 0 is the LSB.
REQ-023 ks_last=1 when remaining <= BATCH_BLOCKS at the time the batch is captured.
REQ-024 HOLD: ks_data, ks_mask and ks_last stay stable while ks_valid=1 and ks_ready=0.
REQ-025 HOLD: a transfer occurs on ks_valid&ks_ready.
REQ-026 HOLD, non-last transfer: ctr += BATCH_BLOCKS, remaining -= BATCH_BLOCKS, go to ISSUE; the next eng_start is 1 cycle after the transfer.
REQ-027 HOLD, last transfer: go to IDLE; job_ready returns high the next cycle.
REQ-028 Arithmetic: ctr is modulo 2^CTR_W; remaining is CTR_W+1 bits wide, so 64 is representable.
REQ-029 Arithmetic: ctr cannot wrap within one job.
REQ-030 Latency: job accept to first eng_start is 1 cycle; eng_done to ks_valid is 1 cycle.
REQ-031 abort in ISSUE or HOLD: drop ks_valid and go to IDLE next cycle.
REQ-032 abort in WAIT: go to DRAIN; DRAIN holds eng_nonce/eng_ctr, ignores abort, discards the batch on eng_done, then goes to IDLE.
REQ-033 abort in IDLE has no effect.
REQ-034 abort together with a HOLD transfer: the transfer completes and the FSM then goes to IDLE.
REQ-035 eng_done outside WAIT and DRAIN is ignored.
REQ-036 job_valid outside IDLE is not accepted (job_ready=0).

Reset
REQ-037 On rst_n low, go to IDLE and clear ks_valid, eng_start, busy, ks_last, ks_mask, ctr, remaining and all captured fields to 0.
REQ-038 After reset, job_ready=1.
REQ-039 Reset mid-job discards all state; an eng_done arriving after reset release is ignored (IDLE).

Structure
REQ-040 A shared package holds the state enumeration, BATCH_BLOCKS, CTR_W, BLOCK_W=128 and NONCE_W=16.
REQ-041 The output register with its stable-hold logic is one sub-module, ks_out_reg.
REQ-042 The FSM and counter logic stay in the top module.

Verification
REQ-043 Scenario: job nblocks=8, nonce=16'hA55A, ks_ready=1 -> two eng_start pulses with eng_ctr 0 then 4; masks 1111, 1111; ks_last on batch 2 only.
REQ-044 Scenario: nblocks=6 -> masks 1111 then 0011; ks_last=1 on batch 2.
REQ-045 Scenario: nblocks=0 -> 16 batches; eng_ctr runs 0,4,...,60; final mask 1111 with ks_last=1.
REQ-046 Scenario: ks_ready low for 10 cycles in HOLD -> ks_data stable, no eng_start; after the transfer, eng_start follows 1 cycle later.
REQ-047 Scenario: abort in WAIT -> DRAIN, eng_done consumed with no ks_valid, then IDLE with job_ready=1.
REQ-048 Scenario: rst_n asserted in HOLD -> ks_valid=0 asynchronously; job_ready=1 after release.

Source files
------------

// File: rtl/ctr_batch_scheduler_pkg.sv
// ctr_batch_scheduler_pkg: shared sizes and FSM state encoding for the CTR batch scheduler
package ctr_batch_scheduler_pkg;
  localparam int BATCH_BLOCKS = 4;
  localparam int CTR_W        = 6;
  localparam int BLOCK_W      = 128;
  localparam int NONCE_W      = 16;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_DRAIN} state_e;
endpackage

// File: rtl/ctr_batch_scheduler_ks_out_reg.sv
// ks_out_reg: keystream output register that holds data/mask/last stable until accepted
//   load            capture data_in/mask_in/last_in and raise ks_valid
//   clear           drop ks_valid without a transfer (abort)
//   ks_ready        downstream accept; ks_valid falls after a transfer
//   ks_valid/ks_data/ks_mask/ks_last  registered keystream batch
module ks_out_reg
  import ctr_batch_scheduler_pkg::*;
#(
  parameter int NB = BATCH_BLOCKS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  clear,
  input  logic                  ks_ready,
  input  logic [NB*BLOCK_W-1:0] data_in,
  input  logic [NB-1:0]         mask_in,
  input  logic                  last_in,
  output logic                  ks_valid,
  output logic [NB*BLOCK_W-1:0] ks_data,
  output logic [NB-1:0]         ks_mask,
  output logic                  ks_last
);
  logic                  valid_q, valid_d, last_q, last_d;
  logic [NB*BLOCK_W-1:0] data_q, data_d;
  logic [NB-1:0]         mask_q, mask_d;
  always_comb begin
    valid_d = load | (valid_q & ~ks_ready & ~clear);
    data_d  = load ? data_in : data_q;
    mask_d  = load ? mask_in : mask_q;
    last_d  = load ? last_in : last_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
    end
  assign ks_valid = valid_q;
  assign ks_data  = data_q;
  assign ks_mask  = mask_q;
  assign ks_last  = last_q;
endmodule

// File: rtl/ctr_batch_scheduler.sv
// ctr_batch_scheduler: splits a CTR job into batches of BATCH_BLOCKS AES blocks
//   job_valid/job_ready, job_nonce, job_nblocks (0 = 2^CTR_W)  job request
//   abort                                                       cancel current job
//   eng_start, eng_nonce, eng_ctr / eng_done, eng_batch         AES engine launch/return
//   ks_valid/ks_ready, ks_data, ks_mask, ks_last                keystream output
//   busy                                                        FSM not idle
module ctr_batch_scheduler #(
  parameter int BATCH_BLOCKS = ctr_batch_scheduler_pkg::BATCH_BLOCKS,
  parameter int CTR_W        = ctr_batch_scheduler_pkg::CTR_W
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                job_valid,
  output logic                                                job_ready,
  input  logic [ctr_batch_scheduler_pkg::NONCE_W-1:0]         job_nonce,
  input  logic [CTR_W-1:0]                                    job_nblocks,
  input  logic                                                abort,
  output logic                                                eng_start,
  output logic [ctr_batch_scheduler_pkg::NONCE_W-1:0]         eng_nonce,
  output logic [CTR_W-1:0]                                    eng_ctr,
  input  logic                                                eng_done,
  input  logic [BATCH_BLOCKS*ctr_batch_scheduler_pkg::BLOCK_W-1:0] eng_batch,
  output logic                                                ks_valid,
  input  logic                                                ks_ready,
  output logic [BATCH_BLOCKS*ctr_batch_scheduler_pkg::BLOCK_W-1:0] ks_data,
  output logic [BATCH_BLOCKS-1:0]                             ks_mask,
  output logic                                                ks_last,
  output logic                                                busy
);
  import ctr_batch_scheduler_pkg::*;
  localparam logic [CTR_W:0]          REM_B = (CTR_W+1)'(BATCH_BLOCKS);
  localparam logic [BATCH_BLOCKS-1:0] ALL   = '1;
  state_e               state_q, state_d;
  logic [NONCE_W-1:0]   nonce_q, nonce_d;
  logic [CTR_W-1:0]     ctr_q, ctr_d;
  logic [CTR_W:0]       rem_q, rem_d;
  logic                 eng_start_q, busy_q, job_ready_q;
  logic                 load, clear, xfer, last_c;
  logic [BATCH_BLOCKS-1:0] mask_c;
  assign xfer   = ks_valid & ks_ready;
  assign last_c = rem_q <= REM_B;
  assign mask_c = (rem_q >= REM_B) ? ALL : ~(ALL << rem_q);
  always_comb begin
    state_d = state_q;
    nonce_d = nonce_q;
    ctr_d   = ctr_q;
    rem_d   = rem_q;
    load    = 1'b0;
    clear   = 1'b0;
    case (state_q)
      S_IDLE: if (job_valid) begin
        nonce_d = job_nonce;
        rem_d   = (job_nblocks == '0) ? (CTR_W+1)'(1) << CTR_W : {1'b0, job_nblocks};
        ctr_d   = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = abort ? S_IDLE : S_WAIT;
      // abort coinciding with eng_done has nothing left to drain
      S_WAIT: if (abort) state_d = eng_done ? S_IDLE : S_DRAIN;
        else if (eng_done) begin
          load    = 1'b1;
          state_d = S_HOLD;
        end
      S_HOLD: if (xfer) begin
        if (ks_last || abort) state_d = S_IDLE;
        else begin
          ctr_d   = ctr_q + CTR_W'(BATCH_BLOCKS);
          rem_d   = rem_q - REM_B;
          state_d = S_ISSUE;
        end
      end else if (abort) begin
        clear   = 1'b1;
        state_d = S_IDLE;
      end
      S_DRAIN: if (eng_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= S_IDLE;
      nonce_q     <= '0;
      ctr_q       <= '0;
      rem_q       <= '0;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
      job_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      nonce_q     <= nonce_d;
      ctr_q       <= ctr_d;
      rem_q       <= rem_d;
      eng_start_q <= state_d == S_ISSUE;
      busy_q      <= state_d != S_IDLE;
      job_ready_q <= state_d == S_IDLE;
    end
  assign eng_start = eng_start_q;
  assign busy      = busy_q;
  assign job_ready = job_ready_q;
  assign eng_nonce = nonce_q;
  assign eng_ctr   = ctr_q;
  ks_out_reg #(.NB(BATCH_BLOCKS)) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .clear    (clear),
    .ks_ready (ks_ready),
    .data_in  (eng_batch),
    .mask_in  (mask_c),
    .last_in  (last_c),
    .ks_valid (ks_valid),
    .ks_data  (ks_data),
    .ks_mask  (ks_mask),
    .ks_last  (ks_last)
  );
endmodule
